// File: rtl/edge_event_arbiter.sv
// Per-channel edge detector with pending flags, round-robin serialised onto one valid/ready port.
// Optional macro EDGE_ARB_NEG_EN enables falling-edge events; otherwise only rising edges are seen.
module edge_event_arbiter #(
    parameter int unsigned N      = 4,
    parameter int unsigned CODE_W = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N-1:0]      i_in,
    input  logic              i_evt_ready,
    output logic              o_evt_valid,
    output logic [CODE_W-1:0] o_evt_chan,
    output logic              o_evt_pol,
    output logic              o_pend_any,
    output logic              o_ovf
);

    typedef enum logic [0:0] {StIdle, StOffer} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [N-1:0]      r_prev;
    logic [N-1:0]      r_rise_pend;
    logic [N-1:0]      w_rise_edge;
    logic [N-1:0]      w_fall_pend;
    logic [N-1:0]      w_fall_ovf;
    logic [N-1:0]      w_any_pend;
    logic [N-1:0]      w_clr_sel;
    logic [N-1:0]      w_clr_rise;
    logic [CODE_W-1:0] r_ptr;
    logic [CODE_W-1:0] r_evt_chan;
    logic [CODE_W-1:0] w_win_chan;
    logic [CODE_W-1:0] w_ptr_inc;
    logic              w_found;
    logic              w_win_pol;
    logic              w_load;
    logic              w_ovf_set;
    logic              r_ovf;
    int                w_idx;

    assign w_rise_edge = i_in & ~r_prev;
    assign w_any_pend  = r_rise_pend | w_fall_pend;
    assign o_pend_any  = |w_any_pend;
    assign o_ovf       = r_ovf;

    // Scan from r_ptr upward with wrap; the first channel holding any flag wins.
    always_comb begin
        w_found    = 1'b0;
        w_win_chan = '0;
        w_idx      = 0;
        for (int k = 0; k < int'(N); k++) begin
            w_idx = (int'(r_ptr) + k) % int'(N);
            if (!w_found && w_any_pend[w_idx]) begin
                w_found    = 1'b1;
                w_win_chan = CODE_W'(w_idx);
            end
        end
    end

    assign w_win_pol = r_rise_pend[w_win_chan];
    assign w_load    = (r_state == StIdle) && w_found;
    assign w_ptr_inc = (r_evt_chan == CODE_W'(N - 1)) ? '0 : r_evt_chan + 1'b1;

    always_comb begin
        w_clr_sel = '0;
        if (w_load) begin
            w_clr_sel[w_win_chan] = 1'b1;
        end
    end

    assign w_clr_rise = w_clr_sel & {N{w_win_pol}};
    // A flag cleared on the same edge it is re-set is not an overflow; the set wins.
    assign w_ovf_set  = |(w_rise_edge & r_rise_pend & ~w_clr_rise) | (|w_fall_ovf);

`ifdef EDGE_ARB_NEG_EN
    logic [N-1:0] r_fall_pend;
    logic [N-1:0] w_fall_edge;
    logic [N-1:0] w_clr_fall;
    logic         r_evt_pol;

    assign w_fall_edge = ~i_in & r_prev;
    assign w_clr_fall  = w_clr_sel & {N{~w_win_pol}};
    assign w_fall_pend = r_fall_pend;
    assign w_fall_ovf  = w_fall_edge & r_fall_pend & ~w_clr_fall;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fall_pend <= '0;
            r_evt_pol   <= 1'b0;
        end else begin
            r_fall_pend <= (r_fall_pend & ~w_clr_fall) | w_fall_edge;
            if (w_load) begin
                r_evt_pol <= w_win_pol;
            end
        end
    end

    assign o_evt_pol = r_evt_pol;
`else
    assign w_fall_pend = '0;
    assign w_fall_ovf  = '0;
    assign o_evt_pol   = 1'b1;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev      <= '0;
            r_rise_pend <= '0;
            r_ovf       <= 1'b0;
            r_evt_chan  <= '0;
            r_ptr       <= '0;
        end else begin
            r_prev      <= i_in;
            r_rise_pend <= (r_rise_pend & ~w_clr_rise) | w_rise_edge;
            r_ovf       <= r_ovf | w_ovf_set;
            if (w_load) begin
                r_evt_chan <= w_win_chan;
            end
            if ((r_state == StOffer) && i_evt_ready) begin
                r_ptr <= w_ptr_inc;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_found) w_state_d = StOffer;
            StOffer: if (i_evt_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        o_evt_valid = (r_state == StOffer);
        o_evt_chan  = r_evt_chan;
    end

endmodule
